// File: rtl/aes_kexp_multi_if.sv
// Purpose : bundles the key-expansion start handshake, status and round-key read port.
// Ports   : start_i/start_rdy_o valid/ready start; mode_i, key_i job inputs; busy_o, kv_o,
//           err_o, nr_o status; rk_idx_i/rk_o round-key read port; inv_i (AES_KEXP_INVKEY_EN only).
// Modports: master = key-load / round datapath side, slave = aes_kexp_multi.
interface aes_kexp_multi_if #(
   parameter int RD_IDX_W = 4
);
   logic                start_i;
   logic                start_rdy_o;
   logic [1:0]          mode_i;
   logic [255:0]        key_i;
   logic                busy_o;
   logic                kv_o;
   logic                err_o;
   logic [3:0]          nr_o;
   logic [RD_IDX_W-1:0] rk_idx_i;
   logic [127:0]        rk_o;
`ifdef AES_KEXP_INVKEY_EN
   logic                inv_i;

   modport master (
      output start_i, mode_i, key_i, rk_idx_i, inv_i,
      input  start_rdy_o, busy_o, kv_o, err_o, nr_o, rk_o
   );
   modport slave (
      input  start_i, mode_i, key_i, rk_idx_i, inv_i,
      output start_rdy_o, busy_o, kv_o, err_o, nr_o, rk_o
   );
`else
   modport master (
      output start_i, mode_i, key_i, rk_idx_i,
      input  start_rdy_o, busy_o, kv_o, err_o, nr_o, rk_o
   );
   modport slave (
      input  start_i, mode_i, key_i, rk_idx_i,
      output start_rdy_o, busy_o, kv_o, err_o, nr_o, rk_o
   );
`endif
endinterface

// File: rtl/aes_kexp_multi.sv
// Purpose : runtime AES-128/192/256 key expansion, one schedule word per cycle into a local store.
// Latency : kv_o high 4(Nr+1)-Nk+1 cycles after the accept cycle (+Nr-1 with AES_KEXP_INVKEY_EN).
// Backpr. : start_rdy_o low while expanding; starts presented then are dropped, requester holds.
// Ports   : clk, rst (synchronous, active-low), kx (aes_kexp_multi_if.slave).
// Option  : define AES_KEXP_INVKEY_EN to add the INVERT pass, the inverse store and kx.inv_i.
module aes_kexp_multi #(
   parameter int MAX_NK   = 8,
   parameter int RD_IDX_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   aes_kexp_multi_if.slave kx
);
   localparam int MAX_NR = MAX_NK + 6;
   localparam int NWORDS = 4 * (MAX_NR + 1);
   localparam int WI_W   = $clog2(NWORDS);

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

`ifdef AES_KEXP_INVKEY_EN
   // GF(2^8) multiply by a 4-bit constant built from xtime chains.
   function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] x2, x4, x8, r;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      r  = 8'h00;
      if (c[0]) r = r ^ b;
      if (c[1]) r = r ^ x2;
      if (c[2]) r = r ^ x4;
      if (c[3]) r = r ^ x8;
      return r;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gm(a0, 4'd14) ^ gm(a1, 4'd11) ^ gm(a2, 4'd13) ^ gm(a3, 4'd9),
              gm(a0, 4'd9)  ^ gm(a1, 4'd14) ^ gm(a2, 4'd11) ^ gm(a3, 4'd13),
              gm(a0, 4'd13) ^ gm(a1, 4'd9)  ^ gm(a2, 4'd14) ^ gm(a3, 4'd11),
              gm(a0, 4'd11) ^ gm(a1, 4'd13) ^ gm(a2, 4'd9)  ^ gm(a3, 4'd14)};
   endfunction

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXPAND = 2'd1, ST_INVERT = 2'd2, ST_DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXPAND = 2'd1, ST_DONE = 2'd3} state_t;
`endif

   state_t          state_q, state_d;
   logic [31:0]     w_q [NWORDS];
   logic [31:0]     w_d [NWORDS];
   logic [WI_W-1:0] wi_q, wi_d;         // index of the word produced this cycle
   logic [WI_W-1:0] wlast_q, wlast_d;   // 4(Nr+1)-1
   logic [2:0]      wrap_q, wrap_d;     // wi mod Nk, replaces a divider
   logic [3:0]      nk_q, nk_d;
   logic [7:0]      rcon_q, rcon_d;
   logic            kv_q, kv_d;
   logic            err_q, err_d;
   logic [3:0]      nr_q, nr_d;

   logic [3:0]      nk_sel;
   logic            illegal;
   logic [31:0]     t;
   logic [WI_W-1:0] rd_base;
   logic [127:0]    rk_fwd;
   logic [127:0]    rk;

`ifdef AES_KEXP_INVKEY_EN
   // Inverse store holds rounds 1..Nr-1 only; rounds 0 and Nr are identical in both
   // schedules and are served from the forward store.
   logic [127:0]        ivk_q [MAX_NR+1];
   logic [127:0]        ivk_d [MAX_NR+1];
   logic [RD_IDX_W-1:0] rr_q, rr_d;
   logic [WI_W-1:0]     ib;
`endif

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      wi_d    = wi_q;
      wlast_d = wlast_q;
      wrap_d  = wrap_q;
      nk_d    = nk_q;
      rcon_d  = rcon_q;
      kv_d    = kv_q;
      err_d   = err_q;
      nr_d    = nr_q;
      t       = 32'h0;
`ifdef AES_KEXP_INVKEY_EN
      ivk_d   = ivk_q;
      rr_d    = rr_q;
      ib      = '0;
`endif
      case (kx.mode_i)
         2'd0:    nk_sel = 4'd4;
         2'd1:    nk_sel = 4'd6;
         2'd2:    nk_sel = 4'd8;
         default: nk_sel = 4'd0;
      endcase
      illegal = (nk_sel == 4'd0) || (int'(nk_sel) > MAX_NK);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (kx.start_i) begin
               kv_d = 1'b0;
               if (illegal) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  err_d   = 1'b0;
                  nk_d    = nk_sel;
                  nr_d    = nk_sel + 4'd6;
                  wi_d    = WI_W'(nk_sel);
                  wlast_d = WI_W'({nk_sel + 4'd6, 2'b11});
                  wrap_d  = 3'd0;
                  rcon_d  = 8'h01;
                  for (int k = 0; k < 8; k++) begin
                     if (k < int'(nk_sel)) w_d[k] = kx.key_i[255-32*k -: 32];
                  end
                  state_d = ST_EXPAND;
               end
            end
         end
         ST_EXPAND: begin
            t = w_q[wi_q - WI_W'(1)];
            if (wrap_q == 3'd0) begin
               t      = sub_word({t[23:0], t[31:24]}) ^ {rcon_q, 24'h0};
               rcon_d = xtime(rcon_q);
            end else if (nk_q == 4'd8 && wrap_q == 3'd4) begin
               t = sub_word(t);
            end
            w_d[wi_q] = w_q[wi_q - WI_W'(nk_q)] ^ t;
            wrap_d    = ({1'b0, wrap_q} == nk_q - 4'd1) ? 3'd0 : wrap_q + 3'd1;
            wi_d      = wi_q + WI_W'(1);
            if (wi_q == wlast_q) begin
`ifdef AES_KEXP_INVKEY_EN
               state_d = ST_INVERT;
               rr_d    = RD_IDX_W'(1);
`else
               state_d = ST_DONE;
               kv_d    = 1'b1;
`endif
            end
         end
`ifdef AES_KEXP_INVKEY_EN
         ST_INVERT: begin
            ib = WI_W'({rr_q, 2'b00});
            ivk_d[rr_q] = {inv_mix_col(w_q[ib]),
                           inv_mix_col(w_q[ib + WI_W'(1)]),
                           inv_mix_col(w_q[ib + WI_W'(2)]),
                           inv_mix_col(w_q[ib + WI_W'(3)])};
            rr_d = rr_q + RD_IDX_W'(1);
            if (rr_q == RD_IDX_W'(nr_q - 4'd1)) begin
               state_d = ST_DONE;
               kv_d    = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Store contents are deliberately left out of reset; kv_q gates every read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         wi_q    <= '0;
         wlast_q <= '0;
         wrap_q  <= 3'd0;
         nk_q    <= 4'd0;
         rcon_q  <= 8'h01;
         kv_q    <= 1'b0;
         err_q   <= 1'b0;
         nr_q    <= 4'd0;
`ifdef AES_KEXP_INVKEY_EN
         rr_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         wi_q    <= wi_d;
         wlast_q <= wlast_d;
         wrap_q  <= wrap_d;
         nk_q    <= nk_d;
         rcon_q  <= rcon_d;
         kv_q    <= kv_d;
         err_q   <= err_d;
         nr_q    <= nr_d;
`ifdef AES_KEXP_INVKEY_EN
         rr_q    <= rr_d;
`endif
      end
      w_q <= w_d;
`ifdef AES_KEXP_INVKEY_EN
      ivk_q <= ivk_d;
`endif
   end

   // Read port: zero unless a complete schedule exists and the index is in range.
   always_comb begin
      rd_base = WI_W'({kx.rk_idx_i, 2'b00});
      rk_fwd  = {w_q[rd_base], w_q[rd_base + WI_W'(1)],
                 w_q[rd_base + WI_W'(2)], w_q[rd_base + WI_W'(3)]};
      rk      = 128'h0;
      if (kv_q && (kx.rk_idx_i <= RD_IDX_W'(nr_q))) begin
         rk = rk_fwd;
`ifdef AES_KEXP_INVKEY_EN
         if (kx.inv_i && kx.rk_idx_i != '0 && kx.rk_idx_i != RD_IDX_W'(nr_q))
            rk = ivk_q[kx.rk_idx_i];
`endif
      end
   end

   assign kx.rk_o        = rk;
   assign kx.start_rdy_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
`ifdef AES_KEXP_INVKEY_EN
   assign kx.busy_o      = (state_q == ST_EXPAND) || (state_q == ST_INVERT);
`else
   assign kx.busy_o      = (state_q == ST_EXPAND);
`endif
   assign kx.kv_o        = kv_q;
   assign kx.err_o       = err_q;
   assign kx.nr_o        = nr_q;
endmodule

// File: tb/tb_aes_kexp_multi.sv
// Bench for aes_kexp_multi: FIPS-197 vectors, random keys against a reference built from
// GF(2^8) arithmetic, illegal mode, start-while-busy and mid-run reset.
module tb_aes_kexp_multi;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   aes_kexp_multi_if #(.RD_IDX_W(4)) kif ();
   aes_kexp_multi #(.MAX_NK(8), .RD_IDX_W(4)) dut (.clk(clk), .rst(rst), .kx(kif));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [7:0]  sb [256];
   logic [31:0] mw [60];
   int          m_nk, m_nr;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse (x^254) then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
         end
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic model_expand(input int mode, input logic [255:0] key);
      logic [31:0] t;
      logic [7:0]  rc;
      m_nk = 4 + 2 * mode;
      m_nr = m_nk + 6;
      rc   = 8'h01;
      for (int i = 0; i < m_nk; i++) mw[i] = key[255-32*i -: 32];
      for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
         t = mw[i-1];
         if (i % m_nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (m_nk > 6 && i % m_nk == 4) begin
            t = subw(t);
         end
         mw[i] = mw[i-m_nk] ^ t;
      end
   endtask

   function automatic logic [127:0] mrk(input int r);
      return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
   endfunction

   function automatic int exp_lat();
      int l;
      l = 4 * (m_nr + 1) - m_nk + 1;
`ifdef AES_KEXP_INVKEY_EN
      l = l + m_nr - 1;
`endif
      return l;
   endfunction

`ifdef AES_KEXP_INVKEY_EN
   function automatic logic [127:0] imc(input logic [127:0] rk);
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      logic [127:0] o;
      coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gmul(coef[(k - row + 4) % 4], rk[127-32*c-8*k -: 8]);
            o[127-32*c-8*row -: 8] = acc;
         end
      return o;
   endfunction
`endif

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_kv(inout int cyc);
      while (kif.kv_o !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic verify_all(input string tag);
      chk({tag, ".nr"}, 128'(kif.nr_o), 128'(m_nr));
      for (int r = 0; r <= m_nr; r++) begin
         kif.rk_idx_i = 4'(r);
         @(negedge clk);
         chk($sformatf("%s.rk%0d", tag, r), kif.rk_o, mrk(r));
      end
      kif.rk_idx_i = 4'(m_nr + 1);
      @(negedge clk);
      chk({tag, ".beyond_nr"}, kif.rk_o, 128'h0);
`ifdef AES_KEXP_INVKEY_EN
      kif.inv_i = 1'b1;
      for (int r = 0; r <= m_nr; r++) begin
         kif.rk_idx_i = 4'(r);
         @(negedge clk);
         chk($sformatf("%s.irk%0d", tag, r), kif.rk_o,
             (r == 0 || r == m_nr) ? mrk(r) : imc(mrk(r)));
      end
      kif.inv_i = 1'b0;
`endif
   endtask

   task automatic run_job(input logic [1:0] mode, input logic [255:0] key, input string tag);
      int cyc;
      model_expand(int'(mode), key);
      kif.rk_idx_i = 4'd0;
      kif.mode_i   = mode;
      kif.key_i    = key;
      kif.start_i  = 1'b1;
      tick();
      kif.start_i  = 1'b0;
      cyc = 1;
      chk({tag, ".busy"}, 128'(kif.busy_o), 128'(1));
      chk({tag, ".err_clr"}, 128'(kif.err_o), 128'(0));
      chk({tag, ".rk_hidden"}, kif.rk_o, 128'h0);
      wait_kv(cyc);
      chk({tag, ".latency"}, 128'(cyc), 128'(exp_lat()));
      verify_all(tag);
   endtask

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
      return k;
   endfunction

   initial begin
      logic [255:0] ka, kb;
      int           cyc;
      build_sbox();
      rst          = 1'b0;
      kif.start_i  = 1'b0;
      kif.mode_i   = 2'd0;
      kif.key_i    = '0;
      kif.rk_idx_i = 4'd0;
`ifdef AES_KEXP_INVKEY_EN
      kif.inv_i    = 1'b0;
`endif
      repeat (3) tick();
      chk("reset.rdy",  128'(kif.start_rdy_o), 128'(1));
      chk("reset.busy", 128'(kif.busy_o), 128'(0));
      chk("reset.kv",   128'(kif.kv_o), 128'(0));
      chk("reset.err",  128'(kif.err_o), 128'(0));
      chk("reset.nr",   128'(kif.nr_o), 128'(0));
      chk("reset.rk",   kif.rk_o, 128'h0);
      rst = 1'b1;
      tick();

      run_job(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, "aes128");
      kif.rk_idx_i = 4'd10;
      @(negedge clk);
      chk("aes128.fips_rk10", kif.rk_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run_job(2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, "aes192");
      kif.rk_idx_i = 4'd12;
      @(negedge clk);
      chk("aes192.fips_w51", 128'(kif.rk_o[31:0]), 128'h01002202);

      run_job(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, "aes256");
      kif.rk_idx_i = 4'd14;
      @(negedge clk);
      chk("aes256.fips_w59", 128'(kif.rk_o[31:0]), 128'h706c631e);

      // Reserved mode: rejected on the accept edge, schedule invalidated.
      kif.mode_i  = 2'd3;
      kif.key_i   = rand_key();
      kif.start_i = 1'b1;
      tick();
      kif.start_i = 1'b0;
      chk("illegal.err",  128'(kif.err_o), 128'(1));
      chk("illegal.kv",   128'(kif.kv_o), 128'(0));
      chk("illegal.busy", 128'(kif.busy_o), 128'(0));
      chk("illegal.rdy",  128'(kif.start_rdy_o), 128'(1));
      run_job(2'($urandom_range(0, 2)), rand_key(), "after_illegal");

      // Start pulse while busy must be dropped.
      ka = rand_key();
      kb = rand_key();
      model_expand(1, ka);
      kif.mode_i  = 2'd1;
      kif.key_i   = ka;
      kif.start_i = 1'b1;
      tick();
      kif.start_i = 1'b0;
      cyc = 1;
      while (cyc < 20) begin
         tick();
         cyc++;
      end
      chk("busy_start.rdy", 128'(kif.start_rdy_o), 128'(0));
      kif.mode_i  = 2'd0;
      kif.key_i   = kb;
      kif.start_i = 1'b1;
      tick();
      cyc++;
      kif.start_i = 1'b0;
      wait_kv(cyc);
      chk("busy_start.latency", 128'(cyc), 128'(exp_lat()));
      verify_all("busy_start");

      // Reset in the middle of a run.
      ka = rand_key();
      kif.mode_i  = 2'd2;
      kif.key_i   = ka;
      kif.start_i = 1'b1;
      tick();
      kif.start_i = 1'b0;
      cyc = 1;
      while (cyc < 10) begin
         tick();
         cyc++;
      end
      rst = 1'b0;
      tick();
      chk("midrst.kv",   128'(kif.kv_o), 128'(0));
      chk("midrst.busy", 128'(kif.busy_o), 128'(0));
      rst = 1'b1;
      for (int r = 0; r < 16; r++) begin
         kif.rk_idx_i = 4'(r);
         @(negedge clk);
         chk($sformatf("midrst.rk%0d", r), kif.rk_o, 128'h0);
      end
      run_job(2'd2, ka, "midrst_restart");

      for (int n = 0; n < 4; n++)
         run_job(2'($urandom_range(0, 2)), rand_key(), $sformatf("rand%0d", n));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
